fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the uPower single-cycle datapath. It owns the program counter and drives the word address into the instruction memory, which has a combinational read path. It captures each returned 32-bit instruction with its PC into a 2-entry buffer and hands it to decode over a valid/ready handshake. It also handles branch redirects from execute and halts cleanly when the program runs past the end of instruction memory.

## Interface
- `IMEM_DEPTH`, 3, number of 32-bit words in instruction memory; valid PCs are 0..IMEM_DEPTH-1
- `PC_W`, 32, program counter width
- `RESET_PC`, 0, PC loaded at reset
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle pulse; leaves IDLE; ignored in any other state
- `imem_addr` out PC_W: word index to instruction memory; equals the PC register
- `imem_data` in 32: instruction at `imem_addr`, valid in the same cycle
- `if_valid` out 1: buffer head holds an instruction
- `if_ready` in 1: decode accepts the head this cycle
- `if_instr` out 32: head instruction
- `if_pc` out PC_W: PC of the head instruction
- `redirect_valid` in 1: branch taken; flush and refetch
- `redirect_pc` in PC_W: new word-index PC
- `halted` out 1: program finished, buffer drained
- `fetch_count` out 32: only with FETCH_PERF_CNT_EN
- `stall_count` out 32: only with FETCH_PERF_CNT_EN

## Operation
- FSM states: IDLE, FETCH, DRAIN, HALT.
  - IDLE→FETCH on `start`.
  - FETCH→DRAIN when a push occurs with pc==IMEM_DEPTH-1, or when pc≥IMEM_DEPTH.
  - DRAIN→HALT when the buffer is empty.
  - HALT is terminal until redirect or reset.
- PC is a word index and increments by 1 per push. There is no byte addressing.
- Push rule: in FETCH, when the buffer is not full or a pop occurs the same cycle, write {`imem_data`, pc} and increment pc.
- Pop rule: `if_valid && if_ready`.
- Push and pop in the same cycle keep the occupancy unchanged.
- Buffer full: no push, pc holds, and `imem_addr` is stable.
- Redirect: accepted in FETCH, DRAIN and HALT; ignored in IDLE.
  - On acceptance: flush the buffer, set pc←`redirect_pc`, go to FETCH, and deassert `halted`.
  - Redirect has priority over a same-cycle push. The head popped that cycle still counts as delivered.
- Redirect with `redirect_pc` ≥ IMEM_DEPTH: FETCH sees an out-of-range pc next cycle, goes to DRAIN, then HALT the cycle after.
- `halted`=1 only in HALT.
- Out-of-range pc is never pushed.
- Reset mid-operation: all state returns to its reset value immediately, because reset is asynchronous.
- Reset values:
  - pc=RESET_PC; state=IDLE.
  - Buffer empty, entries 0.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `halted`=0, counters 0.
- `if_instr` and `if_pc` are don't-care while `if_valid`=0.

## Timing
- `start` sampled at edge 0 → FETCH in cycle 1 → push at edge 2 → `if_valid`=1 in cycle 2.
- With `if_ready` held at 1: one instruction per cycle, with no bubbles.
- Redirect sampled at edge N → `imem_addr`=`redirect_pc` in cycle N+1 → the new instruction is on `if_valid` in cycle N+2.
- `if_ready` low for k cycles: the buffer fills in 2 cycles, after which fetch stalls. On release, output resumes with no lost or duplicated instruction.
- `imem_addr` is a pure register output with no combinational input-to-output path.
- `if_valid` depends only on registers.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_count` increments on every push.
  - `stall_count` increments on every cycle with `if_valid && !if_ready`.
  - Both counters saturate at 32'hFFFF_FFFF, clear on `rst`, and are unaffected by redirect.
- Undefined: the counter ports, registers and logic are absent.

## Structure
- Shared package `fetch_ctrl_pkg`: FSM state encodings (2-bit localparams), the instruction width constant 32, and the buffer depth constant 2.
- Sub-module `fetch_skid_fifo`: 2-entry register FIFO of {instr, pc} with push, pop, flush, full and empty signals.
- The top level holds the FSM, PC and counters.

## Test plan
- Reset, `start`, `if_ready`=1, memory {A,B,C} → `if_instr` A,B,C in cycles 2,3,4 with `if_pc` 0,1,2; `halted`=1 by cycle 6.
- `if_ready`=0 for cycles 2–6 → buffer holds A,B; `imem_addr` frozen at 2; after release, A,B,C are delivered in order with no duplicates.
- Redirect to 0 in the cycle B is on the head with `if_ready`=1 → B counted as delivered; next `if_valid` shows A at `if_pc`=0 two cycles later.
- Redirect to 5 with IMEM_DEPTH=3 → DRAIN then HALT; no `if_valid`; `halted`=1 two cycles after the redirect.
- Assert `rst` while the buffer is full in FETCH → all outputs zero immediately; `start` is required again.
- With `FETCH_PERF_CNT_EN`, run the second scenario → `fetch_count`=3 and `stall_count`=5 at halt.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch sequencer: FSM encodings, instruction width
// and skid-buffer depth.
package fetch_ctrl_pkg;

  localparam int INSTR_W   = 32;
  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_DRAIN = 2'd2;
  localparam fetch_state_t ST_HALT  = 2'd3;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry register FIFO holding {instr, pc}; head is always in head_q so the
// output is a pure register read.
module fetch_skid_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [1:0]   count_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;

  assign dout  = head_q;
  assign full  = (count_q == 2'(BUF_DEPTH));
  assign empty = (count_q == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= din;
          else                 tail_q <= din;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        // Simultaneous push/pop: occupancy unchanged, new word lands behind
        // whatever survives the pop.
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= din;
          end else begin
            head_q <= tail_q;
            tail_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, buffers fetched words in a 2-entry
// skid FIFO, handles redirects and halts past end of memory.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer
  import fetch_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = 3,
  parameter int PC_W       = 32,
  parameter int RESET_PC   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted,
  output logic [1:0]         dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  localparam logic [PC_W-1:0] LAST_PC  = PC_W'(IMEM_DEPTH - 1);
  localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(IMEM_DEPTH);

  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic push, pop, redirect_acc, pc_in_range;
  logic fifo_full, fifo_empty;
  logic [INSTR_W+PC_W-1:0] fifo_dout;

  // Handshake: a word transfers to decode on any cycle where if_valid && if_ready
  // are both high at the rising edge; if_valid never depends on if_ready.
  assign pop         = if_valid && if_ready;
  assign if_valid    = !fifo_empty;
  assign imem_addr   = pc_q;
  assign dbg_state   = state_q;
  assign pc_in_range = (pc_q < DEPTH_PC);
  assign {if_instr, if_pc} = fifo_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (redirect_acc)                               state_d = ST_FETCH;
        else if ((push && pc_q == LAST_PC) || !pc_in_range) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (redirect_acc)    state_d = ST_FETCH;
        else if (fifo_empty) state_d = ST_HALT;
      end
      ST_HALT:  if (redirect_acc) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Redirect wins over a same-cycle push; out-of-range pc is never pushed.
  always_comb begin
    redirect_acc = redirect_valid && (state_q != ST_IDLE);
    push         = (state_q == ST_FETCH) && !redirect_acc && pc_in_range &&
                   (!fifo_full || pop);
    halted       = (state_q == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               pc_q <= PC_W'(RESET_PC);
    else if (redirect_acc) pc_q <= redirect_pc;
    else if (push)         pc_q <= pc_q + 1'b1;
  end

  fetch_skid_fifo #(.W(INSTR_W + PC_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_acc),
    .din   ({imem_data, pc_q}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push && fetch_count != 32'hFFFF_FFFF)
        fetch_count <= fetch_count + 32'd1;
      if (if_valid && !if_ready && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a scoreboard of expected {instr, pc}
// deliveries checked by an independent monitor.
module tb_fetch_sequencer;
  import fetch_ctrl_pkg::*;

  localparam int PC_W = 32;
  localparam int W    = INSTR_W + PC_W;
  localparam logic [31:0] INS_A = 32'hA000_000A;
  localparam logic [31:0] INS_B = 32'hB000_000B;
  localparam logic [31:0] INS_C = 32'hC000_000C;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [PC_W-1:0]   imem_addr;
  logic [31:0]       imem_data;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [PC_W-1:0]   if_pc;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              halted;
  logic [1:0]        dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       fetch_count;
  logic [31:0]       stall_count;
`endif

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  fetch_sequencer #(.IMEM_DEPTH(3), .PC_W(PC_W), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .dbg_state      (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  always_comb begin
    case (imem_addr)
      32'd0:   imem_data = INS_A;
      32'd1:   imem_data = INS_B;
      32'd2:   imem_data = INS_C;
      default: imem_data = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_delivery: got instr %h pc %0d expected nothing", if_instr, if_pc);
      end else begin
        check("delivery", {if_instr, if_pc}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    exp_q.push_back({instr, pc});
  endtask

  task automatic wait_halted(input int max_cycles);
    int n = 0;
    while (!halted && n < max_cycles) begin
      step(1);
      n++;
    end
    check("halt_reached", 64'(halted), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1: straight-line fetch of A,B,C with if_ready held high
    do_reset();
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_if_valid",  64'(if_valid),  64'd0);
    check("rst_if_instr",  64'(if_instr),  64'd0);
    check("rst_if_pc",     64'(if_pc),     64'd0);
    check("rst_halted",    64'(halted),    64'd0);
    check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
`ifdef FETCH_PERF_CNT_EN
    check("rst_fetch_count", 64'(fetch_count), 64'd0);
    check("rst_stall_count", 64'(stall_count), 64'd0);
`endif
    expect_word(INS_A, 0);
    expect_word(INS_B, 1);
    expect_word(INS_C, 2);
    if_ready = 1'b1;
    pulse_start();                       // now in cycle 1
    check("c1_state",    64'(dbg_state), 64'(ST_FETCH));
    check("c1_if_valid", 64'(if_valid),  64'd0);
    step(1);                             // cycle 2
    check("c2_if_valid", 64'(if_valid),  64'd1);
    check("c2_if_pc",    64'(if_pc),     64'd0);
    step(3);                             // cycle 5
    check("c5_halted",   64'(halted),    64'd0);
    step(1);                             // cycle 6
    check("c6_halted",   64'(halted),    64'd1);
    check("s1_drained",  64'(exp_q.size()), 64'd0);

    // Scenario 2: decode stalls in cycles 2..6
    do_reset();
    expect_word(INS_A, 0);
    expect_word(INS_B, 1);
    expect_word(INS_C, 2);
    pulse_start();                       // cycle 1
    step(3);                             // cycle 4, buffer full
    check("stall_addr_c4",  64'(imem_addr), 64'd2);
    check("stall_valid_c4", 64'(if_valid),  64'd1);
    check("stall_head_c4",  {if_instr, if_pc}, {INS_A, 32'd0});
    step(2);                             // cycle 6
    check("stall_addr_c6",  64'(imem_addr), 64'd2);
    check("stall_head_c6",  {if_instr, if_pc}, {INS_A, 32'd0});
    step(1);                             // cycle 7
    if_ready = 1'b1;
    wait_halted(10);
    check("s2_drained", 64'(exp_q.size()), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_count", 64'(fetch_count), 64'd3);
    check("perf_stall_count", 64'(stall_count), 64'd5);
`endif

    // Scenario 3: redirect to 0 while B sits on the head and is accepted
    do_reset();
    expect_word(INS_A, 0);
    expect_word(INS_B, 1);
    expect_word(INS_A, 0);
    expect_word(INS_B, 1);
    expect_word(INS_C, 2);
    if_ready = 1'b1;
    pulse_start();                       // cycle 1
    step(2);                             // cycle 3
    check("redir_head_pc", 64'(if_pc), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    step(1);                             // cycle 4
    redirect_valid = 1'b0;
    check("redir_flush_valid", 64'(if_valid),  64'd0);
    check("redir_addr",        64'(imem_addr), 64'd0);
    step(1);                             // cycle 5
    check("redir_new_valid", 64'(if_valid), 64'd1);
    check("redir_new_pc",    64'(if_pc),    64'd0);
    wait_halted(10);
    check("s3_drained", 64'(exp_q.size()), 64'd0);

    // Scenario 4: redirect out of range from HALT
    redirect_valid = 1'b1;
    redirect_pc = 32'd5;
    step(1);
    redirect_valid = 1'b0;
    check("oor_halted_clear", 64'(halted),    64'd0);
    check("oor_addr",         64'(imem_addr), 64'd5);
    check("oor_state_fetch",  64'(dbg_state), 64'(ST_FETCH));
    step(1);
    check("oor_state_drain",  64'(dbg_state), 64'(ST_DRAIN));
    check("oor_no_valid",     64'(if_valid),  64'd0);
    step(1);
    check("oor_halted",       64'(halted),    64'd1);
    check("oor_no_valid2",    64'(if_valid),  64'd0);

    // Scenario 5: asynchronous reset with a full buffer
    do_reset();
    pulse_start();                       // cycle 1
    step(3);                             // cycle 4
    check("pre_rst_valid", 64'(if_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_if_valid",  64'(if_valid),  64'd0);
    check("arst_if_instr",  64'(if_instr),  64'd0);
    check("arst_if_pc",     64'(if_pc),     64'd0);
    check("arst_imem_addr", 64'(imem_addr), 64'd0);
    check("arst_halted",    64'(halted),    64'd0);
    check("arst_state",     64'(dbg_state), 64'(ST_IDLE));
`ifdef FETCH_PERF_CNT_EN
    check("arst_fetch_count", 64'(fetch_count), 64'd0);
`endif
    step(1);
    rst = 1'b0;
    if_ready = 1'b1;
    step(3);
    check("post_rst_idle",  64'(dbg_state), 64'(ST_IDLE));
    check("post_rst_valid", 64'(if_valid),  64'd0);
    expect_word(INS_A, 0);
    expect_word(INS_B, 1);
    expect_word(INS_C, 2);
    pulse_start();
    wait_halted(10);
    step(1);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
